activation_unit: RTL and testbench
==================================

# activation_unit

Multi-lane bias-add and activation stage that sits between the neuron accumulators and the next layer's input buffer. It accepts one beat of `LANES` accumulator sums plus per-lane biases and applies a run-time-selected activation: none, ReLU, leaky ReLU or clamped ReLU. It saturates results to the neuron output width and delivers them through a valid/ready handshake with a 2-stage pipeline. It replaces the counter-gated single-neuron activation with flow-controlled, multi-lane, multi-mode operation and saturation accounting.

## Interface
Parameters:
- `LANES`, 4, neurons processed per beat
- `IN_W`, 33, signed accumulator width per lane
- `B_W`, 17, signed bias width per lane (B_W ≤ IN_W)
- `OUT_W`, 17, signed output width per lane
- `LEAK_SHIFT`, 3, leaky slope = 2^-LEAK_SHIFT (arithmetic right shift)
- `CLAMP_MAX`, 255, upper bound in CLAMP mode (0 < CLAMP_MAX ≤ 2^(OUT_W-1)-1)
- `CNT_W`, 16, saturation counter width

Ports:
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `in_valid` in 1: input beat valid
- `in_ready` out 1: unit can accept a beat
- `in_acc` in LANES*IN_W: lane i at [i*IN_W +: IN_W], signed
- `in_bias` in LANES*B_W: lane i at [i*B_W +: B_W], signed
- `in_mode` in 2: 0 NONE, 1 RELU, 2 LEAKY, 3 CLAMP; sampled with the beat
- `in_last` in 1: end-of-layer marker, passed through
- `out_valid` out 1: output beat valid
- `out_ready` in 1: downstream accepts
- `out_data` out LANES*OUT_W: lane i at [i*OUT_W +: OUT_W], signed
- `out_sat` out LANES: per-lane flag, result was saturated to the OUT_W range
- `out_last` out 1: `in_last` of the same beat
- `sat_clr` in 1: synchronous clear of `sat_count`
- `sat_count` out CNT_W: count of saturated lane-results, sticks at all-ones

## Operation
- Stage 1 (on accept): per lane, sum = sext(acc) + sext(bias) at IN_W+1 bits, which cannot overflow. Mode and last are registered alongside.
- Stage 2 (on advance): per lane, apply the activation to `sum`:
  - NONE: v = sum
  - RELU: v = sum > 0 ? sum : 0
  - LEAKY: v = sum ≥ 0 ? sum : sum >>> LEAK_SHIFT (arithmetic; rounds toward −inf)
  - CLAMP: v = min(max(sum,0), CLAMP_MAX)
- Saturation: if v > 2^(OUT_W-1)-1 or v < −2^(OUT_W-1), output the bound and set `out_sat[i]`. CLAMP bounding is not saturation.
- `sat_count` adds popcount(out_sat) on each output handshake (`out_valid && out_ready`). It saturates at 2^CNT_W−1. When `sat_clr` is asserted in the same cycle as an increment, `sat_clr` wins and the result is 0.
- Lanes are independent. Each beat carries its own mode, so mode changes take effect per beat with no flush.

## Timing
- Advance enable: en = out_ready || !out_valid. `in_ready` = en, combinational from `out_ready` and state. There is no combinational path from `in_valid` to `in_ready`.
- Accept = in_valid && in_ready. When en is high, stage 1 loads the input beat, or a bubble if not accepted, and stage 2 loads stage 1.
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N+1. Throughput is 1 beat/cycle while `out_ready`=1.
- Stall (`out_ready`=0, `out_valid`=1): `out_data`, `out_sat` and `out_last` hold stable, both stages hold, and `in_ready`=0.
- A bubble in stage 2 with stage 1 full advances regardless of `out_ready`.
- Reset (asserted at any time, including mid-transfer):
  - All valids go to 0. `out_data`, `out_sat`, `out_last` and `sat_count` go to 0. In-flight beats are dropped.
  - `in_ready` is 1 during and after reset.
- `out_data` is not guaranteed zero when `out_valid`=0, except after reset.

## Structure
- Package `activation_pkg`: enum `act_mode_e` (NONE, RELU, LEAKY, CLAMP) and a function for OUT_W saturation bounds.
- Sub-module `activation_lane`: one lane's bias add, activation and saturation datapath, plus its stage registers, instantiated `LANES` times under shared enables.
- The top level holds the valid/last/mode pipeline, handshake logic and `sat_count`.

## Test plan
Use default parameters (OUT_W=17, range −65536..65535, LEAK_SHIFT=3, CLAMP_MAX=255).
- acc=−100, bias=20 in NONE/RELU/LEAKY/CLAMP -> −80 / 0 / −10 / 0, `out_sat`=0. Output valid 2 cycles after accept.
- acc=70000, bias=0 in NONE -> 65535, sat=1. acc=−70000 in NONE -> −65536, sat=1. acc=−70000 in LEAKY -> −8750, sat=0.
- acc=300 in CLAMP -> 255, sat=0. acc=−9 in LEAKY -> −2, showing rounding toward −inf.
- Stream 8 beats with `out_ready` toggling 1,0,0,1,… -> every beat is delivered exactly once, in order, with `in_last` preserved, and output is stable across stalls.
- 3 beats with 4, 1 and 0 saturated lanes -> `sat_count`=5. Assert `sat_clr` in the same cycle as a 2-lane saturated handshake -> `sat_count`=0.
- Assert `rst` while 2 beats are in flight -> `out_valid`=0 and outputs are 0 immediately (asynchronous). A beat sent after deassertion emerges after 2 cycles.

Source files
------------

// File: rtl/activation_pkg.sv
// Shared types and helpers for the activation unit: activation mode encoding
// and the signed bounds of an OUT_W-bit output.
package activation_pkg;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_RELU  = 2'd1,
        MODE_LEAKY = 2'd2,
        MODE_CLAMP = 2'd3
    } act_mode_e;

    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/activation_lane.sv
// One lane: stage 1 registers the bias-added sum, stage 2 registers the
// activated and saturated result. Both stages load under the shared enable.
module activation_lane
    import activation_pkg::*;
#(
    parameter int IN_W       = 33,
    parameter int B_W        = 17,
    parameter int OUT_W      = 17,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_MAX  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  acc,
    input  logic signed [B_W-1:0]   bias,
    input  act_mode_e               mode,
    output logic signed [OUT_W-1:0] data,
    output logic                    sat
);

    localparam int SW = IN_W + 1;
    localparam logic signed [SW-1:0] HI   = SW'(sat_hi(OUT_W));
    localparam logic signed [SW-1:0] LO   = SW'(sat_lo(OUT_W));
    localparam logic signed [SW-1:0] CMAX = SW'(CLAMP_MAX);

    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    act;
    logic signed [OUT_W-1:0] res;
    logic                    res_sat;

    // One extra bit of headroom means the bias add can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (en) begin
            sum <= {acc[IN_W-1], acc} + {{(SW-B_W){bias[B_W-1]}}, bias};
        end
    end

    always_comb begin
        act = sum;
        case (mode)
            MODE_NONE:  act = sum;
            MODE_RELU:  act = sum[SW-1] ? '0 : sum;
            MODE_LEAKY: act = sum[SW-1] ? (sum >>> LEAK_SHIFT) : sum;
            MODE_CLAMP: begin
                if (sum[SW-1])      act = '0;
                else if (sum > CMAX) act = CMAX;
                else                 act = sum;
            end
            default:    act = sum;
        endcase
    end

    always_comb begin
        res     = act[OUT_W-1:0];
        res_sat = 1'b0;
        if (act > HI) begin
            res     = HI[OUT_W-1:0];
            res_sat = 1'b1;
        end else if (act < LO) begin
            res     = LO[OUT_W-1:0];
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            sat  <= 1'b0;
        end else if (en) begin
            data <= res;
            sat  <= res_sat;
        end
    end

endmodule

// File: rtl/activation_unit.sv
// Multi-lane bias-add + activation stage: 2-stage valid/ready pipeline with
// per-beat mode selection and a sticky saturation counter.
module activation_unit
    import activation_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int IN_W       = 33,
    parameter int B_W        = 17,
    parameter int OUT_W      = 17,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_MAX  = 255,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_acc,
    input  logic [LANES*B_W-1:0]   in_bias,
    input  logic [1:0]             in_mode,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    output logic                   out_last,
    input  logic                   sat_clr,
    output logic [CNT_W-1:0]       sat_count
);

    // Handshake: a beat moves on a cycle where valid and ready are both high.
    // Both stages advance together whenever the output is free or drained.
    logic      en;
    logic      s1_valid;
    logic      s1_last;
    act_mode_e s1_mode;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_mode   <= MODE_NONE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_last   <= in_last;
            s1_mode   <= act_mode_e'(in_mode);
            out_valid <= s1_valid;
            out_last  <= s1_last;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        activation_lane #(
            .IN_W       (IN_W),
            .B_W        (B_W),
            .OUT_W      (OUT_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .CLAMP_MAX  (CLAMP_MAX)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .acc  (in_acc[i*IN_W +: IN_W]),
            .bias (in_bias[i*B_W +: B_W]),
            .mode (s1_mode),
            .data (out_data[i*OUT_W +: OUT_W]),
            .sat  (out_sat[i])
        );
    end

    logic [CNT_W:0] pop;
    logic [CNT_W:0] cnt_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + (CNT_W+1)'(out_sat[i]);
        end
        cnt_sum = {1'b0, sat_count} + pop;
    end

    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready) begin
            sat_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_activation_unit.sv
// Directed-vector bench for activation_unit with a queue scoreboard and an
// independent output monitor.
module tb_activation_unit;

    localparam int LANES = 4;
    localparam int IN_W  = 33;
    localparam int B_W   = 17;
    localparam int OUT_W = 17;
    localparam int CNT_W = 16;
    localparam int PW    = LANES*OUT_W + LANES + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_acc;
    logic [LANES*B_W-1:0]   in_bias;
    logic [1:0]             in_mode;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_sat;
    logic                   out_last;
    logic                   sat_clr;
    logic [CNT_W-1:0]       sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] held;
    bit            held_v = 1'b0;

    activation_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_bias   (in_bias),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_last  (out_last),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checks ----------------
    task automatic check(input string name, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [PW-1:0] got;
        logic [PW-1:0] want;
        got = {out_data, out_sat, out_last};
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) begin
                n_tests++;
                if (got !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h expected %h", got, held);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL beat: got data=%h sat=%b last=%b expected data=%h sat=%b last=%b",
                                 got[PW-1:LANES+1], got[LANES:1], got[0],
                                 want[PW-1:LANES+1], want[LANES:1], want[0]);
                    end
                end
            end
            held_v = out_valid && !out_ready;
            held   = got;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [1:0] mode, input bit last,
                        input int a0, input int a1, input int a2, input int a3,
                        input int b,
                        input int e0, input int e1, input int e2, input int e3,
                        input logic [3:0] s);
        int a[4];
        int e[4];
        logic signed [IN_W-1:0]  av;
        logic signed [B_W-1:0]   bv;
        logic signed [OUT_W-1:0] ev;
        logic [LANES*OUT_W-1:0]  ed;
        bit rdy;
        bit ok;
        a = '{a0, a1, a2, a3};
        e = '{e0, e1, e2, e3};
        bv = B_W'(b);
        for (int i = 0; i < LANES; i++) begin
            av = IN_W'(a[i]);
            ev = OUT_W'(e[i]);
            in_acc[i*IN_W +: IN_W]  = av;
            in_bias[i*B_W +: B_W]   = bv;
            ed[i*OUT_W +: OUT_W]    = ev;
        end
        in_mode  = mode;
        in_last  = last;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (ok) begin
            exp_q.push_back({ed, s, last});
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready expected accept within 100 cycles");
        end
    endtask

    task automatic send_vec(input int k, input bit last);
        case (k)
            1: send(2'd0, last, -100, 1000, -65556, 65515, 20, -80, 1020, -65536, 65535, 4'b0000);
            2: send(2'd1, last, -100, -20, -19, 500, 20, 0, 0, 1, 520, 4'b0000);
            3: send(2'd2, last, -100, -29, -28, 1000, 20, -10, -2, -1, 1020, 4'b0000);
            4: send(2'd3, last, -100, 235, 236, 100000, 20, 0, 255, 255, 255, 4'b0000);
            5: send(2'd0, last, 70000, -70000, 65536, -65537, 0, 65535, -65536, 65535, -65536, 4'b1111);
            6: send(2'd2, last, -70000, -9, 70000, -524288, 0, -8750, -2, 65535, -65536, 4'b0100);
            7: send(2'd3, last, 300, -5, 0, 255, 0, 255, 0, 0, 255, 4'b0000);
            8: send(2'd1, last, 100000, 0, 40001, 200000, -40000, 60000, 0, 1, 65535, 4'b1000);
            default: send(2'd0, last, 70000, -70000, 5, 6, 0, 65535, -65536, 5, 6, 4'b0011);
        endcase
    endtask

    // Beat was accepted at the edge just before entry, pipeline otherwise empty.
    task automatic lat_check(input string name);
        @(negedge clk);
        check({name, "_after_n"}, out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, "_after_n1"}, out_valid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic wait_out_valid();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("wait_out_valid", seen, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        in_valid = 1'b0;
        in_acc = '0;
        in_bias = '0;
        in_mode = 2'd0;
        in_last = 1'b0;
        out_ready = 1'b1;
        sat_clr = 1'b0;

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_count", sat_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_vec(1, 1'b0);
        lat_check("latency");
        drain();

        for (int k = 1; k <= 8; k++) send_vec(k, 1'b0);
        drain();

        fork
            begin
                for (int k = 1; k <= 8; k++) send_vec(k, (k == 4) || (k == 8));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = pat[c % 4];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        @(negedge clk);
        check("sat_count_accum", sat_count, 12);

        @(posedge clk);
        #1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        @(negedge clk);
        check("sat_clr_idle", sat_count, 0);
        @(posedge clk);
        #1;

        send_vec(5, 1'b0);
        send_vec(6, 1'b0);
        send_vec(7, 1'b0);
        drain();
        @(negedge clk);
        check("sat_count_4_1_0", sat_count, 5);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send_vec(5, 1'b0);
        send_vec(9, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", longint'(out_data), 0);
        check("midrst_out_sat", out_sat, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_sat_count", sat_count, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_vec(2, 1'b1);
        lat_check("post_rst_latency");
        drain();

        send_vec(6, 1'b0);
        drain();
        @(negedge clk);
        check("sat_count_one", sat_count, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_vec(9, 1'b0);
        wait_out_valid();
        sat_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        @(negedge clk);
        check("sat_clr_wins", sat_count, 0);
        @(posedge clk);
        #1;
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
